// File: rtl/slvs_ec_pkg.sv
// Code words, header layout and state encodings shared by the SLVS-EC TX framer.
package slvs_ec_pkg;

   localparam logic [1:0]  K_NONE = 2'b00;
   localparam logic [1:0]  K_IDLE = 2'b10;
   localparam logic [1:0]  K_BOTH = 2'b11;

   localparam logic [15:0] W_IDLE = 16'hBC50;
   localparam logic [15:0] W_SC0  = 16'hBCFB;
   localparam logic [15:0] W_SC1  = 16'h5CFB;
   localparam logic [15:0] W_EC0  = 16'hBCFD;
   localparam logic [15:0] W_EC1  = 16'hFEFD;

   typedef struct packed {
      logic        fs;
      logic        fe;
      logic        valid;
      logic [12:0] line_num;
   } hdr0_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SC0,
      ST_SC1,
      ST_HDR0,
      ST_HDR1,
      ST_PAYLOAD,
      ST_DROP,
      ST_EC0,
      ST_EC1,
      ST_GAP
   } state_t;

   typedef enum logic [2:0] {
      SEL_IDLE,
      SEL_SC0,
      SEL_SC1,
      SEL_HDR,
      SEL_DATA,
      SEL_EC0,
      SEL_EC1
   } word_sel_t;

endpackage

// File: rtl/slvs_ec_lane_mux.sv
// Registered TX word select: control and header words go to every lane, payload passes per lane.
module slvs_ec_lane_mux
   import slvs_ec_pkg::*;
#(
   parameter int LANES = 8
) (
   input  logic                img_tx_clk,
   input  logic                img_tx_rst_n,
   input  word_sel_t           sel,
   input  logic [15:0]         hdr_word,
   input  logic [16*LANES-1:0] pay_data,
   output logic [16*LANES-1:0] tx_data_o,
   output logic [2*LANES-1:0]  tx_ctrl_o
);

   logic [15:0] ctrl_word;
   logic [1:0]  ctrl_k;

   always_comb begin
      ctrl_word = W_IDLE;
      ctrl_k    = K_IDLE;
      case (sel)
         SEL_SC0: begin ctrl_word = W_SC0;    ctrl_k = K_BOTH; end
         SEL_SC1: begin ctrl_word = W_SC1;    ctrl_k = K_BOTH; end
         SEL_EC0: begin ctrl_word = W_EC0;    ctrl_k = K_BOTH; end
         SEL_EC1: begin ctrl_word = W_EC1;    ctrl_k = K_BOTH; end
         SEL_HDR: begin ctrl_word = hdr_word; ctrl_k = K_NONE; end
         default: ;
      endcase
   end

   always_ff @(posedge img_tx_clk or negedge img_tx_rst_n) begin
      if (!img_tx_rst_n) begin
         tx_data_o <= {LANES{W_IDLE}};
         tx_ctrl_o <= {LANES{K_IDLE}};
      end else if (sel == SEL_DATA) begin
         tx_data_o <= pay_data;
         tx_ctrl_o <= '0;
      end else begin
         tx_data_o <= {LANES{ctrl_word}};
         tx_ctrl_o <= {LANES{ctrl_k}};
      end
   end

endmodule

// File: rtl/slvs_ec_tx_framer.sv
// SLVS-EC transmit framer: wraps each AXIS line as SC, header, payload, EC and paces packets with idles.
module slvs_ec_tx_framer
   import slvs_ec_pkg::*;
#(
   parameter int LANES     = 8,
   parameter int GAP_WORDS = 4,
   parameter int BEAT_W    = 12
) (
   input  logic                img_tx_clk,
   input  logic                img_tx_rst_n,
   input  logic                tx_enable,
   input  logic [12:0]         frame_lines,
   input  logic [BEAT_W-1:0]   line_beats,
   input  logic [16*LANES-1:0] s_tdata,
   input  logic                s_tvalid,
   output logic                s_tready,
   input  logic                s_tlast,
   input  logic                s_tuser,
   output logic [16*LANES-1:0] tx_data_o,
   output logic [2*LANES-1:0]  tx_ctrl_o,
   output logic [12:0]         line_cnt_o,
   output logic                frame_done_o,
   output logic                err_short_o,
   output logic                err_long_o,
   input  logic                err_clr,
   output logic                busy_o
);
   // state     | meaning
   // IDLE      | waiting for tx_enable with a beat pending
   // SC0/SC1   | start code words
   // HDR0/HDR1 | header: flags + line number, then beat count
   // PAYLOAD   | forwarding beats, idle word on stall
   // DROP      | discarding the tail of an over-long line
   // EC0/EC1   | end code words
   // GAP       | GAP_WORDS idle words before the next packet

   localparam int               GAP_W  = $clog2(GAP_WORDS + 1);
   localparam logic [GAP_W-1:0] GAP_TC = GAP_W'(GAP_WORDS - 1);

   state_t            state;
   logic [GAP_W-1:0]  gap_cnt;
   logic [BEAT_W-1:0] beat_cnt;
   logic [BEAT_W-1:0] beats_q;
   hdr0_t             hdr0_q;
   logic              long_q;
   logic [12:0]       next_line;
   logic              done_arm;

   logic [12:0]       line_pick;
   logic              fe_pick;
   logic              beat_take;
   logic [BEAT_W-1:0] cnt_nxt;
   logic              set_short;
   logic              set_long;
   word_sel_t         sel;
   logic [15:0]       hdr_word;

   // Line number is peeked from s_tuser without consuming the beat.
   assign line_pick = s_tuser ? 13'd0 : next_line;
   assign fe_pick   = (line_pick == frame_lines - 13'd1);
   assign beat_take = s_tvalid & s_tready;
   assign cnt_nxt   = beat_cnt + BEAT_W'(1);
   assign set_short = (state == ST_PAYLOAD) & beat_take & s_tlast & (cnt_nxt != beats_q);
   assign set_long  = (state == ST_PAYLOAD) & beat_take & ~s_tlast & (cnt_nxt == beats_q);

   always_comb begin
      sel      = SEL_IDLE;
      hdr_word = 16'(beats_q);
      case (state)
         ST_SC0:     sel = SEL_SC0;
         ST_SC1:     sel = SEL_SC1;
         ST_HDR0:    begin sel = SEL_HDR; hdr_word = hdr0_q; end
         ST_HDR1:    sel = SEL_HDR;
         ST_PAYLOAD: if (s_tvalid) sel = SEL_DATA;
         ST_EC0:     sel = SEL_EC0;
         ST_EC1:     sel = SEL_EC1;
         default:    ;
      endcase
   end

   always_ff @(posedge img_tx_clk or negedge img_tx_rst_n) begin
      if (!img_tx_rst_n) begin
         state        <= ST_GAP;
         gap_cnt      <= '0;
         beat_cnt     <= '0;
         beats_q      <= '0;
         hdr0_q       <= '0;
         long_q       <= 1'b0;
         next_line    <= '0;
         line_cnt_o   <= '0;
         done_arm     <= 1'b0;
         frame_done_o <= 1'b0;
         err_short_o  <= 1'b0;
         err_long_o   <= 1'b0;
         s_tready     <= 1'b0;
         busy_o       <= 1'b0;
      end else begin
         s_tready     <= 1'b0;
         done_arm     <= 1'b0;
         frame_done_o <= done_arm;

         if (set_short)    err_short_o <= 1'b1;
         else if (err_clr) err_short_o <= 1'b0;
         if (set_long)     err_long_o  <= 1'b1;
         else if (err_clr) err_long_o  <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (tx_enable && s_tvalid) begin
                  state      <= ST_SC0;
                  busy_o     <= 1'b1;
                  beats_q    <= line_beats;
                  hdr0_q     <= '{fs: s_tuser, fe: fe_pick, valid: 1'b1, line_num: line_pick};
                  line_cnt_o <= line_pick;
                  next_line  <= fe_pick ? 13'd0 : line_pick + 13'd1;
                  long_q     <= 1'b0;
                  beat_cnt   <= '0;
               end
            end
            ST_SC0:  state <= ST_SC1;
            ST_SC1:  state <= ST_HDR0;
            ST_HDR0: state <= ST_HDR1;
            ST_HDR1: begin
               state    <= ST_PAYLOAD;
               s_tready <= 1'b1;
            end
            ST_PAYLOAD: begin
               s_tready <= 1'b1;
               if (beat_take) begin
                  beat_cnt <= cnt_nxt;
                  if (s_tlast || cnt_nxt == beats_q) begin
                     state    <= ST_EC0;
                     s_tready <= 1'b0;
                     long_q   <= ~s_tlast;
                  end
               end
            end
            ST_EC0: state <= ST_EC1;
            ST_EC1: begin
               done_arm <= hdr0_q.fe;
               if (long_q) begin
                  state    <= ST_DROP;
                  s_tready <= 1'b1;
               end else begin
                  state   <= ST_GAP;
                  busy_o  <= 1'b0;
                  gap_cnt <= '0;
               end
            end
            ST_DROP: begin
               s_tready <= 1'b1;
               if (beat_take && s_tlast) begin
                  state    <= ST_GAP;
                  s_tready <= 1'b0;
                  busy_o   <= 1'b0;
                  gap_cnt  <= '0;
               end
            end
            ST_GAP: begin
               if (gap_cnt == GAP_TC) state   <= ST_IDLE;
               else                   gap_cnt <= gap_cnt + GAP_W'(1);
            end
            default: state <= ST_GAP;
         endcase
      end
   end

   slvs_ec_lane_mux #(.LANES(LANES)) u_lane_mux (
      .img_tx_clk   (img_tx_clk),
      .img_tx_rst_n (img_tx_rst_n),
      .sel          (sel),
      .hdr_word     (hdr_word),
      .pay_data     (s_tdata),
      .tx_data_o    (tx_data_o),
      .tx_ctrl_o    (tx_ctrl_o)
   );

endmodule

// File: tb/tb_slvs_ec_tx_framer.sv
// Bench for slvs_ec_tx_framer: table-driven lines checked against a wire-word scoreboard.
module tb_slvs_ec_tx_framer;

   localparam int          GAPW   = 4;
   localparam int          NROWS  = 12;
   localparam logic [15:0] T_IDLE = 16'hBC50;
   localparam logic [15:0] T_SC0  = 16'hBCFB;
   localparam logic [15:0] T_SC1  = 16'h5CFB;
   localparam logic [15:0] T_EC0  = 16'hBCFD;
   localparam logic [15:0] T_EC1  = 16'hFEFD;

   typedef struct {
      logic [127:0] data;
      logic [15:0]  ctrl;
   } word_t;

   typedef struct {
      bit          tuser;
      logic [12:0] fl;
      logic [11:0] lb;
      int          nb;
      bit          stall;
      logic [15:0] hdr0;
      bit          done;
      bit          es;
      bit          el;
      bit          clr;
   } row_t;

   logic         clk, rst_n, tx_enable, s_tvalid, s_tready, s_tlast, s_tuser, err_clr;
   logic [12:0]  frame_lines, line_cnt_o;
   logic [11:0]  line_beats;
   logic [127:0] s_tdata, tx_data_o;
   logic [15:0]  tx_ctrl_o;
   logic         frame_done_o, err_short_o, err_long_o, busy_o;

   word_t exp_q[$];
   bit    done_q[$];
   row_t  rows[NROWS];
   row_t  ra, rb, rc, rd;
   int    n_total, n_bad, idle_run, pkt_idles;
   bit    mon_en, in_pkt, chk_done, exp_done;

   slvs_ec_tx_framer #(.LANES(8), .GAP_WORDS(GAPW), .BEAT_W(12)) dut (
      .img_tx_clk   (clk),
      .img_tx_rst_n (rst_n),
      .tx_enable    (tx_enable),
      .frame_lines  (frame_lines),
      .line_beats   (line_beats),
      .s_tdata      (s_tdata),
      .s_tvalid     (s_tvalid),
      .s_tready     (s_tready),
      .s_tlast      (s_tlast),
      .s_tuser      (s_tuser),
      .tx_data_o    (tx_data_o),
      .tx_ctrl_o    (tx_ctrl_o),
      .line_cnt_o   (line_cnt_o),
      .frame_done_o (frame_done_o),
      .err_short_o  (err_short_o),
      .err_long_o   (err_long_o),
      .err_clr      (err_clr),
      .busy_o       (busy_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [127:0] rep16(input logic [15:0] w);
      return {8{w}};
   endfunction

   function automatic logic [15:0] repk(input logic [1:0] k);
      return {8{k}};
   endfunction

   function automatic word_t mk(input logic [15:0] w, input logic [1:0] k);
      word_t r;
      r.data = rep16(w);
      r.ctrl = repk(k);
      return r;
   endfunction

   function automatic logic [127:0] pat(input int seed, input int b);
      logic [127:0] v;
      logic [7:0]   s8;
      s8 = 8'(seed);
      for (int l = 0; l < 8; l++) v[16*l +: 16] = {s8[3:0], 4'(l), 8'(b)};
      return v;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input logic [127:0] act);
      n_total++;
      n_bad++;
      $display("FAIL %s: got %h want nothing", name, act);
   endtask

   task automatic push_packet(input row_t r, input int seed);
      word_t w;
      int    np;
      np = (r.nb < int'(r.lb)) ? r.nb : int'(r.lb);
      exp_q.push_back(mk(T_SC0, 2'b11));
      exp_q.push_back(mk(T_SC1, 2'b11));
      exp_q.push_back(mk(r.hdr0, 2'b00));
      exp_q.push_back(mk(16'(r.lb), 2'b00));
      for (int i = 0; i < np; i++) begin
         w.data = pat(seed, i);
         w.ctrl = '0;
         exp_q.push_back(w);
      end
      exp_q.push_back(mk(T_EC0, 2'b11));
      exp_q.push_back(mk(T_EC1, 2'b11));
      done_q.push_back(r.done);
   endtask

   task automatic send_line(input int seed, input int nb, input bit tuser, input bit stall, input bit last_en);
      for (int i = 0; i < nb; i++) begin
         int n;
         n = 0;
         if (stall && i > 0) begin
            s_tvalid = 1'b0;
            @(negedge clk);
         end
         s_tvalid = 1'b1;
         s_tdata  = pat(seed, i);
         s_tlast  = last_en && (i == nb - 1);
         s_tuser  = (i == 0) ? tuser : 1'b0;
         while (!s_tready && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (n >= 100) fail("handshake_timeout", 128'(i));
         @(negedge clk);
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tuser  = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy_o) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) fail("drain_timeout", 128'(exp_q.size()));
      repeat (2) @(negedge clk);
   endtask

   task automatic check_row(input row_t r);
      check("line_cnt", 128'(line_cnt_o), 128'(r.hdr0[12:0]));
      check("err_short", 128'(err_short_o), 128'(r.es));
      check("err_long", 128'(err_long_o), 128'(r.el));
      check("pkt_idles", 128'(pkt_idles), 128'(r.stall ? r.nb - 1 : 0));
      if (r.clr) begin
         err_clr = 1'b1;
         @(negedge clk);
         err_clr = 1'b0;
         check("err_short_clr", 128'(err_short_o), 128'd0);
         check("err_long_clr", 128'(err_long_o), 128'd0);
      end
   endtask

   // Scoreboard monitor: every non-idle wire word must match the front of exp_q.
   initial begin
      word_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (chk_done) begin
               check("frame_done", 128'(frame_done_o), 128'(exp_done));
               chk_done = 1'b0;
            end else if (frame_done_o) begin
               fail("frame_done_spurious", 128'(frame_done_o));
            end
            if (tx_ctrl_o == repk(2'b10)) begin
               check("idle_word", tx_data_o, rep16(T_IDLE));
               if (in_pkt) pkt_idles++;
               else        idle_run++;
            end else if (exp_q.size() == 0) begin
               fail("unexpected_word", tx_data_o);
            end else begin
               e = exp_q.pop_front();
               check("wire_data", tx_data_o, e.data);
               check("wire_ctrl", 128'(tx_ctrl_o), 128'(e.ctrl));
               if (e.data == rep16(T_SC0) && e.ctrl == repk(2'b11)) begin
                  check("gap_len", 128'(idle_run >= GAPW), 128'd1);
                  in_pkt    = 1'b1;
                  pkt_idles = 0;
               end
               if (e.data == rep16(T_EC1) && e.ctrl == repk(2'b11)) begin
                  in_pkt   = 1'b0;
                  idle_run = 0;
                  chk_done = 1'b1;
                  exp_done = (done_q.size() != 0) ? done_q.pop_front() : 1'b0;
               end
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; tx_enable = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
      s_tdata = '0; err_clr = 1'b0; frame_lines = 13'd1; line_beats = 12'd4;
      n_total = 0; n_bad = 0; mon_en = 1'b0; in_pkt = 1'b0; chk_done = 1'b0;
      exp_done = 1'b0; idle_run = 0; pkt_idles = 0;

      //          tuser  fl      lb      nb stall hdr0      done es    el    clr
      rows[0]  = '{1'b1, 13'd1, 12'd4, 4, 1'b0, 16'hE000, 1'b1, 1'b0, 1'b0, 1'b0};
      rows[1]  = '{1'b1, 13'd3, 12'd4, 4, 1'b0, 16'hA000, 1'b0, 1'b0, 1'b0, 1'b0};
      rows[2]  = '{1'b0, 13'd3, 12'd4, 4, 1'b0, 16'h2001, 1'b0, 1'b0, 1'b0, 1'b0};
      rows[3]  = '{1'b0, 13'd3, 12'd4, 4, 1'b0, 16'h6002, 1'b1, 1'b0, 1'b0, 1'b0};
      rows[4]  = '{1'b0, 13'd3, 12'd4, 4, 1'b0, 16'h2000, 1'b0, 1'b0, 1'b0, 1'b0};
      rows[5]  = '{1'b1, 13'd3, 12'd8, 5, 1'b0, 16'hA000, 1'b0, 1'b1, 1'b0, 1'b1};
      rows[6]  = '{1'b0, 13'd3, 12'd4, 8, 1'b0, 16'h2001, 1'b0, 1'b0, 1'b1, 1'b1};
      rows[7]  = '{1'b0, 13'd3, 12'd4, 4, 1'b0, 16'h6002, 1'b1, 1'b0, 1'b0, 1'b0};
      rows[8]  = '{1'b1, 13'd1, 12'd4, 4, 1'b1, 16'hE000, 1'b1, 1'b0, 1'b0, 1'b0};
      rows[9]  = '{1'b1, 13'd1, 12'd1, 1, 1'b0, 16'hE000, 1'b1, 1'b0, 1'b0, 1'b0};
      rows[10] = '{1'b1, 13'd2, 12'd3, 3, 1'b0, 16'hA000, 1'b0, 1'b0, 1'b0, 1'b0};
      rows[11] = '{1'b0, 13'd2, 12'd3, 3, 1'b0, 16'h6001, 1'b1, 1'b0, 1'b0, 1'b0};
      ra = '{1'b1, 13'd1, 12'd4, 4, 1'b0, 16'hE000, 1'b1, 1'b0, 1'b0, 1'b0};
      rb = '{1'b1, 13'd3, 12'd2, 2, 1'b0, 16'hA000, 1'b0, 1'b0, 1'b0, 1'b0};
      rc = '{1'b1, 13'd1, 12'd8, 8, 1'b0, 16'hE000, 1'b1, 1'b0, 1'b0, 1'b0};
      rd = '{1'b1, 13'd1, 12'd4, 4, 1'b0, 16'hE000, 1'b1, 1'b0, 1'b0, 1'b0};

      repeat (2) @(negedge clk);
      check("rst_data", tx_data_o, rep16(T_IDLE));
      check("rst_ctrl", 128'(tx_ctrl_o), 128'(repk(2'b10)));
      check("rst_tready", 128'(s_tready), 128'd0);
      check("rst_line_cnt", 128'(line_cnt_o), 128'd0);
      check("rst_frame_done", 128'(frame_done_o), 128'd0);
      check("rst_errs", 128'({err_short_o, err_long_o}), 128'd0);
      check("rst_busy", 128'(busy_o), 128'd0);

      mon_en    = 1'b1;
      rst_n     = 1'b1;
      tx_enable = 1'b1;

      for (int k = 0; k < NROWS; k++) begin
         frame_lines = rows[k].fl;
         line_beats  = rows[k].lb;
         push_packet(rows[k], k);
         send_line(k, rows[k].nb, rows[k].tuser, rows[k].stall, 1'b1);
         wait_drain();
         check_row(rows[k]);
      end

      // tx_enable dropped once the packet has started: it must still complete
      frame_lines = ra.fl;
      line_beats  = ra.lb;
      push_packet(ra, 20);
      fork
         send_line(20, ra.nb, ra.tuser, 1'b0, 1'b1);
         begin
            int n;
            n = 0;
            while (!busy_o && n < 50) begin
               @(negedge clk);
               n++;
            end
            if (n >= 50) fail("busy_timeout", 128'(n));
            tx_enable = 1'b0;
         end
      join
      wait_drain();
      check_row(ra);

      // parked in IDLE with a beat waiting: nothing may be sent
      frame_lines = rb.fl;
      line_beats  = rb.lb;
      s_tvalid = 1'b1; s_tuser = 1'b1; s_tlast = 1'b0; s_tdata = pat(21, 0);
      repeat (20) @(negedge clk);
      check("park_busy", 128'(busy_o), 128'd0);
      check("park_tready", 128'(s_tready), 128'd0);
      push_packet(rb, 21);
      tx_enable = 1'b1;
      send_line(21, rb.nb, rb.tuser, 1'b0, 1'b1);
      wait_drain();
      check_row(rb);

      // reset in the middle of the payload
      frame_lines = rc.fl;
      line_beats  = rc.lb;
      push_packet(rc, 22);
      send_line(22, 3, rc.tuser, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_data", tx_data_o, rep16(T_IDLE));
      check("midrst_ctrl", 128'(tx_ctrl_o), 128'(repk(2'b10)));
      check("midrst_tready", 128'(s_tready), 128'd0);
      check("midrst_line_cnt", 128'(line_cnt_o), 128'd0);
      check("midrst_busy", 128'(busy_o), 128'd0);
      mon_en = 1'b0;
      exp_q.delete();
      done_q.delete();
      in_pkt = 1'b0; chk_done = 1'b0; idle_run = 0; pkt_idles = 0;
      repeat (2) @(negedge clk);
      mon_en = 1'b1;
      rst_n  = 1'b1;
      frame_lines = rd.fl;
      line_beats  = rd.lb;
      push_packet(rd, 23);
      send_line(23, rd.nb, rd.tuser, 1'b0, 1'b1);
      wait_drain();
      check_row(rd);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
